bus_arbiter_2to1: RTL and testbench



---
 rtl/bus_arbiter_2to1_pkg.sv | 16 +
 rtl/bus_arbiter_2to1_hold_counter.sv | 40 ++++
 rtl/bus_arbiter_2to1.sv | 151 +++++++++++++++
 tb/tb_bus_arbiter_2to1.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_2to1_pkg.sv
// Shared definitions for the 2:1 bus arbiter.
//   state_t          : arbiter FSM states (IDLE, GRANT0, GRANT1)
//   DEFAULT_WIDTH    : default data width of the shared bus
//   DEFAULT_MAX_HOLD : default grant-hold bound under contention
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/bus_arbiter_2to1_hold_counter.sv
// Grant-hold counter for the 2:1 bus arbiter.
// Counts consecutive grant cycles and saturates at MAX_HOLD.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset (count -> 0)
//   clear  : synchronous clear (count -> 0), wins over enable
//   enable : count this cycle
//   count  : current hold count, saturating at MAX_HOLD
//   expire : the current grant has used up its contended hold budget
module arb_hold_counter #(
  parameter int MAX_HOLD = 16,
  localparam int HOLD_W  = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [HOLD_W-1:0] count,
  output logic              expire
);

  localparam logic [HOLD_W-1:0] SAT_VAL  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] LAST_VAL = HOLD_W'(MAX_HOLD - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT_VAL)) begin
      count <= count + HOLD_W'(1);
    end
  end

  // Under contention from the first grant cycle this fires exactly at
  // MAX_HOLD-1. Using >= keeps the bound when a competitor only shows up
  // after an uncontended grant has already saturated the counter.
  assign expire = (count >= LAST_VAL);

endmodule

// File: rtl/bus_arbiter_2to1.sv
// 2:1 round-robin bus arbiter with bounded hold time.
// Shares one WIDTH-bit data path between two requesters, drives the mux
// select and registers the selected byte onto the downstream bus.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   req0, req1 : level requests, held while the bus is needed
//   din0, din1 : requester data, valid while the matching gnt is high
//   gnt0, gnt1 : grants, decoded from registered state
//   sel        : mux select (0 = din0, 1 = din1)
//   bus_out    : registered selected data
//   bus_valid  : bus_out was captured under a grant
//   busy       : some grant is active
import arb_pkg::*;

module bus_arbiter_2to1 #(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid,
  output logic             busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_t              state;
  state_t              state_next;
  logic                last;
  logic                rel_grant;
  logic                hold_clear;
  logic                hold_en;
  logic                expire;
  logic [HOLD_W-1:0]   hold_cnt;

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clear  (hold_clear),
    .enable (hold_en),
    .count  (hold_cnt),
    .expire (expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; every grant returns through IDLE so there is always
  // one turnaround cycle with no grant between the two sources.
  always_comb begin
    state_next = state;
    rel_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          // last names the requester served most recently; the other wins.
          state_next = last ? GRANT0 : GRANT1;
        end else if (req0) begin
          state_next = GRANT0;
        end else if (req1) begin
          state_next = GRANT1;
        end
      end
      GRANT0: begin
        if (!req0 || (expire && req1)) begin
          rel_grant  = 1'b1;
          state_next = IDLE;
        end
      end
      GRANT1: begin
        if (!req1 || (expire && req0)) begin
          rel_grant  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode from registered state
  always_comb begin
    gnt0       = (state == GRANT0);
    gnt1       = (state == GRANT1);
    busy       = (state == GRANT0) || (state == GRANT1);
    hold_en    = (state != IDLE);
    hold_clear = rel_grant || (state == IDLE);
  end

  // Round-robin memory: updated only when a grant is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (rel_grant) begin
      last <= (state == GRANT1);
    end
  end

  // Select changes only on grant entry and holds through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= 1'b0;
    end else if (state == IDLE) begin
      if (state_next == GRANT0) begin
        sel <= 1'b0;
      end else if (state_next == GRANT1) begin
        sel <= 1'b1;
      end
    end
  end

  // Data capture: one cycle behind the grant; bus_out holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_out   <= '0;
      bus_valid <= 1'b0;
    end else begin
      case (state)
        GRANT0: begin
          bus_out   <= din0;
          bus_valid <= 1'b1;
        end
        GRANT1: begin
          bus_out   <= din1;
          bus_valid <= 1'b1;
        end
        default: begin
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Scoreboard bench for bus_arbiter_2to1 (MAX_HOLD=4).
// The driver applies one input vector per cycle on the falling edge and
// queues the outputs expected after the next rising edge; the monitor pops
// and compares shortly after every rising edge.
module tb_bus_arbiter_2to1;

  typedef struct {
    logic       g0;
    logic       g1;
    logic       sel;
    logic       vld;
    logic [7:0] bus;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] din0 = 8'h00;
  logic [7:0] din1 = 8'h00;
  logic       gnt0, gnt1, sel, bus_valid, busy;
  logic [7:0] bus_out;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   vec_no = 0;

  bus_arbiter_2to1 #(
    .WIDTH    (8),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .din0      (din0),
    .din1      (din1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic r0, input logic r1,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic eg0, input logic eg1, input logic esel,
                      input logic [7:0] ebus, input logic evld);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req0 = r0;
    req1 = r1;
    din0 = d0;
    din1 = d1;
    e.g0  = eg0;
    e.g1  = eg1;
    e.sel = esel;
    e.bus = ebus;
    e.vld = evld;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("gnt0",      vec_no, {7'd0, gnt0},      {7'd0, mon_e.g0});
        chk("gnt1",      vec_no, {7'd0, gnt1},      {7'd0, mon_e.g1});
        chk("sel",       vec_no, {7'd0, sel},       {7'd0, mon_e.sel});
        chk("bus_out",   vec_no, bus_out,           mon_e.bus);
        chk("bus_valid", vec_no, {7'd0, bus_valid}, {7'd0, mon_e.vld});
        chk("busy",      vec_no, {7'd0, busy},      {7'd0, mon_e.g0 | mon_e.g1});
        vec_no++;
      end
    end
  end

  // Driver
  initial begin
    int p;
    logic [7:0] eb;

    // Reset with both requesting and din0=FF; after release requester 0 wins.
    step(1, 1, 1, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 0);
    step(1, 1, 1, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 0);
    step(0, 1, 1, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 8'hFF, 1);
    step(0, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 8'hFF, 0);

    // Single requester 0, three grant cycles, data lags by one.
    step(0, 1, 0, 8'hA5, 8'h00, 1, 0, 0, 8'hFF, 0);
    step(0, 1, 0, 8'hA5, 8'h00, 1, 0, 0, 8'hA5, 1);
    step(0, 1, 0, 8'hA5, 8'h00, 1, 0, 0, 8'hA5, 1);
    step(0, 0, 0, 8'hA5, 8'h00, 0, 0, 0, 8'hA5, 1);
    step(0, 0, 0, 8'hA5, 8'h00, 0, 0, 0, 8'hA5, 0);

    // Round-robin tie after reset: 0 first, then 1 on the next tie.
    step(1, 0, 0, 8'h11, 8'h3C, 0, 0, 0, 8'h00, 0);
    step(0, 1, 1, 8'h11, 8'h3C, 1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h11, 8'h3C, 0, 0, 0, 8'h11, 1);
    step(0, 1, 1, 8'h11, 8'h3C, 0, 1, 1, 8'h11, 0);
    step(0, 1, 1, 8'h11, 8'h3C, 0, 1, 1, 8'h3C, 1);
    step(0, 0, 0, 8'h11, 8'h3C, 0, 0, 1, 8'h3C, 1);
    step(0, 0, 0, 8'h11, 8'h3C, 0, 0, 1, 8'h3C, 0);

    // Preemption: both held for 30 cycles -> 4 g0, idle, 4 g1, idle.
    for (int i = 0; i < 30; i++) begin
      p = i % 10;
      if (i == 0)                eb = 8'h3C;
      else if (p >= 1 && p <= 5) eb = 8'h5A;
      else                       eb = 8'hC3;
      step(0, 1, 1, 8'h5A, 8'hC3,
           (p <= 3), (p >= 5 && p <= 8), (p >= 5), eb, (p != 0 && p != 5));
    end
    step(0, 0, 0, 8'h5A, 8'hC3, 0, 0, 1, 8'hC3, 0);

    // Uncontended requester 1 for 40 cycles: never preempted.
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 8'h00, 8'h77, 0, 1, 1, (i == 0) ? 8'hC3 : 8'h77, (i != 0));
    end
    @(posedge clk);
    #1;
    total++;
    if (dut.u_hold.count !== 3'd4) begin
      bad++;
      $display("FAIL hold_sat got=%0d expected=4", dut.u_hold.count);
    end

    // Reset during the second cycle of a gnt1 grant; tie then favours 0.
    step(0, 0, 0, 8'h00, 8'h77, 0, 0, 1, 8'h77, 1);
    step(0, 0, 1, 8'h00, 8'h99, 0, 1, 1, 8'h77, 0);
    step(0, 0, 1, 8'h00, 8'h99, 0, 1, 1, 8'h99, 1);
    step(1, 1, 1, 8'h44, 8'h99, 0, 0, 0, 8'h00, 0);
    step(0, 1, 1, 8'h44, 8'h99, 1, 0, 0, 8'h00, 0);
    step(0, 1, 1, 8'h44, 8'h99, 1, 0, 0, 8'h44, 1);
    step(0, 0, 0, 8'h44, 8'h99, 0, 0, 0, 8'h44, 1);
    step(0, 0, 0, 8'h44, 8'h99, 0, 0, 0, 8'h44, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
